// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed N-digit hex 7-segment display driver.
// The slow scan square wave is synchronized into the clk_50MHz domain and
// edge-detected. Each scan tick blanks all anodes for GUARD_CYC cycles, then
// drives the next digit from a snapshot taken once per frame (at the wrap to
// digit 0). Optional leading-zero blanking is enabled by defining
// SEG7_LZ_BLANK_EN; the default build drives every digit.
module seg7_scan #(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned GUARD_CYC      = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  clk_scan,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [2:0]            digit_idx,
  output logic                  frame_done
);

  localparam int unsigned CntW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(GUARD_CYC - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [1:0] StOff   = 2'd0;
  localparam logic [1:0] StGuard = 2'd1;
  localparam logic [1:0] StDrive = 2'd2;

  localparam logic [N_DIGITS-1:0] AnOff = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0] SegOff  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DpOff   = SEG_ACTIVE_LOW;
  localparam logic [2:0] LastIdx = 3'(N_DIGITS - 1);

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      default: r = 7'h71;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] nib_at(input logic [4*N_DIGITS-1:0] snap,
                                        input logic [2:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == 3'(i)) r = snap[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic dp_at(input logic [N_DIGITS-1:0] mask, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == 3'(i)) r = mask[i];
    end
    return r;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // True when idx lies above the highest nonzero nibble (digit 0 never blanks).
  function automatic logic lz_blank(input logic [4*N_DIGITS-1:0] snap, input logic [2:0] idx);
    int unsigned h;
    h = 0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (snap[4*i +: 4] != 4'h0) h = i;
    end
    return 32'(idx) > h;
  endfunction
`endif

  logic                  s1_q, s2_q, s3_q;
  logic                  primed_q, armed_q;
  logic                  tick;
  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_q, snap_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;
  logic [N_DIGITS-1:0]   an_on;
  logic                  blank_cur, blank_nxt, load_pat;

  // Synchronize the scan wave. Ticks stay disarmed until a real low sample has
  // been seen after reset, so a scan level held high at release is not an edge.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      s1_q     <= clk_scan;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      primed_q <= 1'b1;
      if (primed_q && !s1_q) armed_q <= 1'b1;
    end
  end

  assign tick = s2_q & ~s3_q & armed_q;

  // Anode pattern and blanking for the digit currently selected.
  always_comb begin
    an_on = {N_DIGITS{1'b0}};
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      an_on[i] = (idx_q == 3'(i));
    end
    if (AN_ACTIVE_LOW) an_on = ~an_on;
`ifdef SEG7_LZ_BLANK_EN
    blank_cur = lz_blank(snap_q, idx_q);
`else
    blank_cur = 1'b0;
`endif
  end

  // Scan FSM next state. seg/dp are loaded only on the cycle the anodes turn
  // off, from the next digit and next snapshot, so they never move while lit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    fd_d      = 1'b0;
    load_pat  = 1'b0;
    blank_nxt = 1'b0;

    if (!en) begin
      state_d = StOff;
      idx_d   = 3'd0;
      an_d    = AnOff;
      seg_d   = SegOff;
      dp_d    = DpOff;
    end else begin
      case (state_q)
        StOff: begin
          an_d  = AnOff;
          idx_d = 3'd0;
          if (tick) begin
            snap_d    = data;
            snap_dp_d = dp_mask;
            cnt_d     = CntLoad;
            state_d   = StGuard;
            load_pat  = 1'b1;
          end
        end
        StGuard: begin
          // Ticks landing here are dropped.
          if (cnt_q == '0) begin
            state_d = StDrive;
            an_d    = blank_cur ? AnOff : an_on;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StDrive: begin
          if (tick) begin
            an_d     = AnOff;
            cnt_d    = CntLoad;
            state_d  = StGuard;
            load_pat = 1'b1;
            if (idx_q == LastIdx) begin
              idx_d     = 3'd0;
              snap_d    = data;
              snap_dp_d = dp_mask;
              fd_d      = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = StOff;
          idx_d   = 3'd0;
          an_d    = AnOff;
        end
      endcase
    end

    if (load_pat) begin
`ifdef SEG7_LZ_BLANK_EN
      blank_nxt = lz_blank(snap_d, idx_d);
`endif
      if (blank_nxt) begin
        seg_d = SegOff;
        dp_d  = DpOff;
      end else begin
        seg_d = SEG_ACTIVE_LOW ? ~hex7(nib_at(snap_d, idx_d)) : hex7(nib_at(snap_d, idx_d));
        dp_d  = dp_at(snap_dp_d, idx_d) ^ SEG_ACTIVE_LOW;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      an_q      <= AnOff;
      seg_q     <= SegOff;
      dp_q      <= DpOff;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed 7-segment display driver that consumes the slow square-wave scan clock from the frequency divider (nominally the 1 kHz output).
- Runs entirely in the clk_50MHz domain. The scan input is synchronized and edge-detected, never used as a clock.
- Displays an N-digit hex word (e.g. CPU PC or register value) on a common-anode/cathode board display.
- Uses a dead-time guard between digits to prevent ghosting, and a frame-coherent data snapshot.

Parameters:
- N_DIGITS, 8: number of digits; range 2..8.
- GUARD_CYC, 4: clk_50MHz cycles all anodes are held off between digits; must be >=1.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp outputs inverted (segment lit when 0).
- AN_ACTIVE_LOW, 1: 1 = anode outputs inverted (digit enabled when 0).

Ports:
- clk_50MHz  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- clk_scan  input  1  slow scan square wave from the divider; asynchronous to this logic.
- en  input  1  display enable.
- data  input  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp_mask  input  N_DIGITS  decimal point request per digit.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.
- an  output  N_DIGITS  digit enables; one-hot active or all inactive.
- digit_idx  output  3  index of the digit currently selected.
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset, synchronous on rst=1 at the clk_50MHz rising edge:
  - an all inactive; seg all unlit; dp unlit.
  - digit_idx=0; frame_done=0; state=OFF.
  - data/dp snapshot cleared to 0; synchronizer flops s1/s2/s3 = 0; guard counter = 0.
  - rst overrides every other input, including mid-GUARD and mid-DRIVE.
- Tick generation:
  - s1<=clk_scan, s2<=s1, s3<=s2; tick = s2 & ~s3.
  - A clk_scan rise first sampled at edge k produces tick during the cycle after edge k+1.
  - The registered outputs respond at edge k+2.
- All outputs are registered.
- State OFF:
  - Anodes inactive; digit_idx=0.
  - On en=1 and tick: snapshot<=data, dp_mask; guard counter<=GUARD_CYC-1; go to GUARD.
- State GUARD:
  - Anodes inactive.
  - Counter decrements each cycle. At counter==0 go to DRIVE.
  - In DRIVE, an[digit_idx] is active, and seg/dp are decoded from snapshot nibble digit_idx.
  - Ticks arriving in GUARD are dropped.
- State DRIVE:
  - Outputs held.
  - On tick: anodes off, counter<=GUARD_CYC-1, go to GUARD.
  - digit_idx<=digit_idx+1, wrapping from N_DIGITS-1 to 0.
  - On wrap: snapshot<=data, dp_mask, and frame_done=1 for exactly that cycle.
- en=0 in any state: next cycle state=OFF, anodes inactive, digit_idx=0. No frame_done is generated.
- seg/dp never change while an anode is active: they change only in the same cycle the anodes go inactive, or while already inactive.
- Hex decode, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Inverted when SEG_ACTIVE_LOW=1.
- Data changes mid-frame are not displayed until the next wrap.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression, evaluated on the snapshot.
  - Let h = index of the highest nonzero nibble (h=0 if all nibbles are zero).
  - For digit_idx>h, DRIVE keeps the anode inactive and seg unlit. Timing and digit_idx sequencing are unchanged.
  - dp_mask does not un-blank a suppressed digit.
- Undefined: all N_DIGITS digits are always driven, including leading zeros.

Test Plan:
- Reset then en=1, data=32'h0000_00A5, clk_scan toggling every 50 cycles (defaults) -> first tick: an=8'hFF for 4 cycles, then an=8'hFE with seg=~7'h6D (5); next tick: after 4 cycles, an=8'hFD with seg=~7'h77 (A).
- Run 8 ticks past start -> digit_idx sequence 0..7 then 0; frame_done pulses exactly once, 1 cycle, on the 7->0 wrap.
- Change data to 32'h1234_5678 while digit_idx=3 -> digits 4..7 still show old snapshot; new value appears from digit 0 of next frame.
- Drop en during DRIVE, digit_idx=5 -> next cycle an=8'hFF, digit_idx=0; re-enable -> restarts at digit 0 with fresh snapshot.
- Assert rst during GUARD -> next edge all outputs at reset values; s1..s3=0; no spurious tick after release with clk_scan=1 held (tick only after clk_scan 0->1).
- With SEG7_LZ_BLANK_EN, data=32'h0000_0030 -> digits 0 and 1 lit ("30"); digits 2..7 anodes stay inactive; data=0 -> only digit 0 shows "0".
